// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency countdown scoreboard for ID-stage hazard stalls
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 3,
    parameter int CW      = $clog2(MAX_LAT + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [AW-1:0]   id_rs_i,
    input  logic [AW-1:0]   id_rt_i,
    input  logic            id_rs_used_i,
    input  logic            id_rt_used_i,
    input  logic            id_we_i,
    input  logic [AW-1:0]   id_rd_i,
    input  logic [CW-1:0]   id_lat_i,
    input  logic            flush_i,
    input  logic            mem_stall_i,
    output logic            stall_o,
    output logic            issue_o,
    output logic [NREG-1:0] busy_mask_o,
    output logic [31:0]     stall_cycles_o
);

    localparam logic [CW:0]   MAX_LAT_W = (CW + 1)'(MAX_LAT);
    localparam logic [CW-1:0] MAX_LAT_C = CW'(MAX_LAT);

    // cnt_q[r] = cycles remaining before register r can be forwarded; entry 0 stays zero
    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [31:0]   stall_cycles_q;
    logic [31:0]   stall_cycles_d;

    logic          rs_pend;
    logic          rt_pend;
    logic          haz;
    logic [CW-1:0] lat_clamp;
    logic [CW:0]   lat_ext;

    // Hazard detection reads the pre-update counters, so a source equal to its own rd never self-stalls
    always_comb begin
        rs_pend   = id_rs_used_i && (id_rs_i != '0) && (cnt_q[id_rs_i] != '0);
        rt_pend   = id_rt_used_i && (id_rt_i != '0) && (cnt_q[id_rt_i] != '0);
        haz       = rs_pend || rt_pend;
        stall_o   = id_valid_i && haz && !flush_i;
        issue_o   = id_valid_i && !haz && !flush_i && !mem_stall_i;
        lat_ext   = {1'b0, id_lat_i};
        lat_clamp = (lat_ext > MAX_LAT_W) ? MAX_LAT_C : id_lat_i;
    end

    // Busy view of the counters for debug and external forwarding logic
    always_comb begin
        busy_mask_o = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_mask_o[r] = (cnt_q[r] != '0);
        end
    end

    // Countdown unless frozen; an issuing writer reloads its destination, overriding the decrement
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < NREG; r++) begin
            if (!mem_stall_i && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
        if (issue_o && id_we_i && (id_rd_i != '0)) begin
            cnt_d[id_rd_i] = lat_clamp;
        end
        cnt_d[0] = '0;
    end

    // Saturating count of hazard stall cycles, excluding memory-freeze cycles
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_o && !mem_stall_i && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // State registers, cleared asynchronously so pending hazards vanish on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load-use / multi-cycle hazard unit for the 32-bit pipelined MIPS core. It sits between ID and EX and keeps a per-register countdown of cycles until an in-flight result can be forwarded. It stalls the instruction in ID while any source it reads is still pending. It generalises the fixed single-bubble load-use stall to any result latency up to `MAX_LAT`, honours a global memory freeze, and counts stall cycles for performance analysis.

## Interface
Parameters:
- `NREG`, 32: architectural register count; register 0 is hard-wired zero.
- `AW`, 5: register index width, `$clog2(NREG)`.
- `MAX_LAT`, 3: largest result latency tracked, in cycles beyond the forwarding point.
- `CW`, `$clog2(MAX_LAT+1)`: counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: a valid instruction is in ID.
- `id_rs`, `id_rt` in AW: source register indices.
- `id_rs_used`, `id_rt_used` in 1: the instruction actually reads that source.
- `id_we` in 1: the instruction writes `id_rd`.
- `id_rd` in AW: destination index.
- `id_lat` in CW: result latency class. 0 = ALU (fully forwarded), 1 = single-cycle load, 2..MAX_LAT = long load or multiply.
- `flush` in 1: kill the instruction in ID this cycle.
- `mem_stall` in 1: global pipeline freeze from the memory system.
- `stall` out 1: hold PC and the IF/ID register, and insert a bubble into EX.
- `issue` out 1: the instruction in ID advances to EX this cycle.
- `busy_mask` out NREG: bit r = pending result for register r.
- `stall_cycles` out 32: saturating hazard-stall counter.

## Operation
- State: `cnt[r]`, CW bits per register, r = 1..NREG-1. `cnt[0]` is constant 0.
- Hazard (combinational), `haz` is true when either holds:
  - `id_rs_used` and `id_rs` != 0 and `cnt[id_rs]` != 0
  - `id_rt_used` and `id_rt` != 0 and `cnt[id_rt]` != 0
- Outputs:
  - `stall = id_valid & haz & ~flush`.
  - `issue = id_valid & ~haz & ~flush & ~mem_stall`.
  - `busy_mask[r] = (cnt[r] != 0)`.
- Counter update each clock edge:
  - If `mem_stall` = 1: all `cnt` hold. No issue and no decrement.
  - Otherwise every nonzero `cnt[r]` decrements by 1.
  - If `issue & id_we & id_rd != 0`: `cnt[id_rd]` is loaded with `min(id_lat, MAX_LAT)`. The load overrides that register's decrement.
- WAW: an issuing writer with `id_lat` = 0 clears a pending `cnt[id_rd]`. The younger ALU result is forwarded and written back last in order.
- Self-dependence: an instruction whose source equals its own `id_rd` uses the pre-update `cnt`; there is no self-stall.
- Writes to r0 are ignored; reads of r0 never stall.
- `stall_cycles` increments when `stall & ~mem_stall`, and saturates at 0xFFFF_FFFF.
- `flush` removes the ID instruction. It neither stalls nor issues, and counters keep decrementing.

## Timing
- Reset (async, while `rst` = 1):
  - all `cnt` = 0, `busy_mask` = 0, `stall_cycles` = 0.
  - `stall` and `issue` follow their combinational definitions with `cnt` = 0.
- A writer issued in cycle t with latency L (L ≥ 1) gives `cnt` = L at t+1. A dependant in ID stalls cycles t+1..t+L and issues at t+L+1. That is exactly L bubbles, and L = 1 is the classic one-bubble load-use stall.
- Each `mem_stall` cycle during the countdown extends the stall by one cycle. Those cycles do not count in `stall_cycles`.
- `stall` has zero latency from the ID inputs (combinational). There is no combinational path from `mem_stall` to `stall`.
- Reset asserted mid-countdown clears all pending state immediately. The first instruction after reset never stalls.

## Test plan
- MAX_LAT = 3. `lw r2` (lat 1) issues at t, then `add r3,r2,r2` is in ID. Required: `stall` = 1 for exactly one cycle, `issue` at t+2. With 7 loaded, r2 ends as 14 (`add` result). `stall_cycles` = 1.
- `lw r5` with lat 3, followed by a dependant reading only rt = r5. Required: three `stall` cycles, issue at t+4, `busy_mask[5]` = 1 during cycles t+1..t+3.
- Same as the lat-3 scenario, with `mem_stall` high for 2 cycles at t+2. Required: dependant issues at t+6, `stall_cycles` = 3, `cnt[5]` frozen at 2 during the freeze.
- `lw r4` (lat 2), then an ALU writer to r4 (lat 0) that issues the next cycle and does not read r4, then a reader of r4. Required: the reader never stalls and `busy_mask[4]` = 0 after the ALU issue.
- `lw r0` (lat 3), then a reader of r0. Required: no stall, `busy_mask` = 0. A dependant of a pending r7 with `id_rs_used` = 0 gives no stall.
- `rst` pulsed while `cnt[9]` = 2 and a dependant is stalling. Required: `busy_mask` = 0, `stall` = 0 and `stall_cycles` = 0 asynchronously. The dependant issues on the first cycle after release.
